// File: rtl/serial_add_ctrl_if.sv
// Handshake and result bundle for the bit-serial adder controller.
// The master drives the operands and start; the slave reports status and the result.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell per clock, WIDTH cycles per operation.
// The result appears on sum/cout together with a one-cycle done pulse.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             cout_r;
  logic [CW-1:0]    cnt_r;
  logic             last_s;
  logic [1:0]       fa_s;
  logic             busy_s;
  logic             done_s;

  // Returns {carry_out, sum_bit} of a single full-adder cell.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    full_add = {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

  assign last_s = (cnt_r == CW'(WIDTH - 1));
  assign fa_s   = full_add(opa_r[0], opb_r[0], carry_r);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
      ST_RUN: begin
        busy_s = 1'b1;
        done_s = 1'b0;
      end
      ST_DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Operand capture, serial datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_r   <= {WIDTH{1'b0}};
      opb_r   <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            opa_r   <= bus.a;
            opb_r   <= bus.b;
            carry_r <= bus.cin;
            cnt_r   <= {CW{1'b0}};
          end
        end
        ST_RUN: begin
          opa_r   <= opa_r >> 1;
          opb_r   <= opb_r >> 1;
          res_r   <= {fa_s[0], res_r[WIDTH-1:1]};
          carry_r <= fa_s[1];
          cnt_r   <= cnt_r + 1'b1;
          // The final bit joins the result in the same edge that enters DONE.
          if (last_s) begin
            sum_r  <= {fa_s[0], res_r[WIDTH-1:1]};
            cout_r <= fa_s[1];
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign bus.busy = busy_s;
  assign bus.done = done_s;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=16: table vectors,
// hand-written corner sequences and random operations, checked through a scoreboard.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_done8 = 0;
  int   prev_done8 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_ctrl_if #(.WIDTH(8))  bus8 ();
  serial_add_ctrl_if #(.WIDTH(16)) bus16 ();

  serial_add_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_add_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  typedef struct {
    logic [16:0] res;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  exp_t q8[$];
  exp_t q16[$];
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard for the 8-bit instance: every done pops one expected result.
  always @(negedge clk) begin : mon8
    exp_t e;
    if (bus8.done === 1'b1) begin
      if (q8.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done8_unexpected: got done=1, expected no pending operation (cycle %0d)", cyc);
      end else begin
        e = q8.pop_front();
        check("sum8", 32'(bus8.sum), 32'(e.res[7:0]));
        check("cout8", 32'(bus8.cout), 32'(e.res[8]));
        check("latency8", 32'(cyc), 32'(e.cyc));
        check("busy_in_done8", 32'(bus8.busy), 32'd1);
        prev_done8 = last_done8;
        last_done8 = cyc;
      end
    end
  end

  // Scoreboard for the 16-bit instance.
  always @(negedge clk) begin : mon16
    exp_t e;
    if (bus16.done === 1'b1) begin
      if (q16.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done16_unexpected: got done=1, expected no pending operation (cycle %0d)", cyc);
      end else begin
        e = q16.pop_front();
        check("sum16", 32'(bus16.sum), 32'(e.res[15:0]));
        check("cout16", 32'(bus16.cout), 32'(e.res[16]));
        check("latency16", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Called #1 after a rising edge; waits for IDLE, issues one start and pushes the expectation.
  task automatic issue(input bit w16, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic [16:0] exp);
    int guard = 0;
    while (((w16 ? bus16.busy : bus8.busy) !== 1'b0) && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 40) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got busy for %0d cycles, expected IDLE within 40", guard);
    end
    if (w16) begin
      bus16.start = 1'b1;
      bus16.a     = a;
      bus16.b     = b;
      bus16.cin   = c;
      q16.push_back('{res: exp, cyc: cyc + 1 + 16});
    end else begin
      bus8.start = 1'b1;
      bus8.a     = a[7:0];
      bus8.b     = b[7:0];
      bus8.cin   = c;
      q8.push_back('{res: exp, cyc: cyc + 1 + 8});
    end
    @(posedge clk);
    #1;
    // Scramble the operands once accepted; the operation in flight must not notice.
    bus8.start  = 1'b0;
    bus16.start = 1'b0;
    bus8.a      = 8'($urandom);
    bus8.b      = 8'($urandom);
    bus8.cin    = 1'($urandom);
    bus16.a     = 16'($urandom);
    bus16.b     = 16'($urandom);
    bus16.cin   = 1'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    while ((q8.size() != 0 || q16.size() != 0) && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain", 32'(q8.size() + q16.size()), 32'd0);
  endtask

  initial begin
    logic [7:0]  ra8;
    logic [7:0]  rb8;
    logic [15:0] ra16;
    logic [15:0] rb16;
    logic        rc;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[8] = '{8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0};

    rst         = 1'b1;
    bus8.start  = 1'b0;
    bus8.a      = 8'h00;
    bus8.b      = 8'h00;
    bus8.cin    = 1'b0;
    bus16.start = 1'b0;
    bus16.a     = 16'h0000;
    bus16.b     = 16'h0000;
    bus16.cin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check("rst_busy8", 32'(bus8.busy), 32'd0);
    check("rst_done8", 32'(bus8.done), 32'd0);
    check("rst_sum8", 32'(bus8.sum), 32'd0);
    check("rst_cout8", 32'(bus8.cout), 32'd0);
    check("rst_busy16", 32'(bus16.busy), 32'd0);
    check("rst_sum16", 32'(bus16.sum), 32'd0);

    // First start is driven in the very cycle rst drops.
    rst = 1'b0;
    foreach (vecs[i]) begin
      issue(1'b0, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, vecs[i].cin,
            {8'h00, vecs[i].cout, vecs[i].sum});
    end
    drain();

    // Back-to-back pair: the second start lands in the IDLE cycle right after done.
    issue(1'b0, 16'h0010, 16'h0020, 1'b0, 17'h00030);
    issue(1'b0, 16'h007F, 16'h0001, 1'b0, 17'h00080);
    drain();
    check("b2b_gap", 32'(last_done8 - prev_done8), 32'd10);

    // start pulses in RUN cycle 3 and in DONE are ignored; busy spans exactly k..k+8.
    bus8.start = 1'b1;
    bus8.a     = 8'h5A;
    bus8.b     = 8'h3C;
    bus8.cin   = 1'b0;
    q8.push_back('{res: 17'h00096, cyc: cyc + 1 + 8});
    @(posedge clk);
    #1;
    for (int t = 0; t <= 10; t++) begin
      bus8.start = ((t == 2) || (t == 8)) ? 1'b1 : 1'b0;
      bus8.a     = 8'hFF;
      bus8.b     = 8'hFF;
      bus8.cin   = 1'b1;
      @(negedge clk);
      check("busy_window8", 32'(bus8.busy), (t <= 8) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    bus8.start = 1'b0;
    drain();

    // Reset in RUN cycle 4 aborts the operation and clears the result.
    bus8.start = 1'b1;
    bus8.a     = 8'h12;
    bus8.b     = 8'h34;
    bus8.cin   = 1'b0;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy8", 32'(bus8.busy), 32'd1);
    @(posedge clk);
    #1;
    check("abort_idle_busy8", 32'(bus8.busy), 32'd0);
    check("abort_done8", 32'(bus8.done), 32'd0);
    check("abort_sum8", 32'(bus8.sum), 32'd0);
    check("abort_cout8", 32'(bus8.cout), 32'd0);
    rst = 1'b0;
    issue(1'b0, 16'h0001, 16'h0002, 1'b0, 17'h00003);
    drain();

    // Random operations against a plain arithmetic reference.
    for (int i = 0; i < 1000; i++) begin
      ra8 = 8'($urandom);
      rb8 = 8'($urandom);
      rc  = 1'($urandom);
      issue(1'b0, {8'h00, ra8}, {8'h00, rb8}, rc,
            17'({1'b0, ra8} + {1'b0, rb8} + {8'h00, rc}));
    end
    for (int i = 0; i < 1000; i++) begin
      ra16 = 16'($urandom);
      rb16 = 16'($urandom);
      rc   = 1'($urandom);
      issue(1'b1, ra16, rb16, rc,
            {1'b0, ra16} + {1'b0, rb16} + {16'h0000, rc});
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits, legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin one addition, sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A, captured on an accepted start.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B, captured on an accepted start.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, captured on an accepted start.
REQ-008 The block SHALL have port busy, output, 1 bit: high in RUN and DONE, low in IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a completed addition.
REQ-010 The block SHALL have port sum, output, WIDTH bits: result register, held until the next completion.
REQ-011 The block SHALL have port cout, output, 1 bit: final carry-out, held with sum.

Function
REQ-012 The block SHALL compute sum/cout using one 1-bit full-adder cell per cycle: s = x^y^c, c_next = (x&y)|(c&(x^y)).
REQ-013 The FSM SHALL have exactly three states, IDLE, RUN and DONE, encoded in 2 bits; the unused encoding SHALL return to IDLE.
REQ-014 In IDLE with start=1, the block SHALL load a and b into shift registers, load cin into the carry flop, clear the bit counter and enter RUN.
REQ-015 In RUN, each cycle the block SHALL add the LSBs of both shift registers with the carry flop, shift the result bit into the MSB of a result shift register, shift both operands right by one, update the carry flop and increment the counter.
REQ-016 When the counter equals WIDTH-1 in RUN, the block SHALL enter DONE on the next edge, with exactly WIDTH RUN cycles per operation.
REQ-017 On entering DONE, sum SHALL take the completed result shift register and cout SHALL take the final carry.
REQ-018 done SHALL be high for exactly the single DONE cycle, after which the FSM SHALL return to IDLE unconditionally.
REQ-019 Latency SHALL be fixed: if start is accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH.
REQ-020 start SHALL be ignored in RUN and DONE, with no queuing and no corruption of the operation in flight.
REQ-021 Changes on a, b or cin after acceptance SHALL NOT affect the operation in flight.
REQ-022 Back-to-back operation SHALL be supported: start asserted in the IDLE cycle right after DONE is accepted, giving a throughput of one result per WIDTH+2 cycles.
REQ-023 sum and cout SHALL change only on entry to DONE or on reset.
REQ-024 Overflow SHALL be reported only through cout, and sum SHALL wrap modulo 2^WIDTH.

Reset
REQ-025 With rst=1 at a clock edge, the FSM SHALL go to IDLE and busy, done, sum, cout, the counter, the carry flop and all shift registers SHALL clear to 0.
REQ-026 rst SHALL take priority over start and over all FSM transitions.
REQ-027 Reset during RUN or DONE SHALL abort the operation, with no done pulse and sum/cout reading 0 afterwards.
REQ-028 The first start SHALL be accepted in the first cycle after rst deasserts.

Verification
REQ-029 WIDTH=8, a=0x5A, b=0x3C, cin=0, start at edge k -> busy high for cycles k..k+8, done pulse after edge k+8, sum=0x96, cout=0.
REQ-030 WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-031 start pulsed with new operands at RUN cycle 3 and again in the DONE cycle -> both ignored, first result unchanged, exactly one done pulse.
REQ-032 rst asserted at RUN cycle 4 of a=0x12, b=0x34 -> IDLE next cycle, busy=0, sum=0, cout=0, no done; a following start with a=0x01, b=0x02 -> sum=0x03.
REQ-033 Two back-to-back operations (0x10+0x20, then 0x7F+0x01 started in the cycle after done) -> done pulses 10 cycles apart, sums 0x30 then 0x80, cout=0 for both.
REQ-034 A randomized run of 1000 operations at WIDTH=8 and WIDTH=16 SHALL check {cout,sum} = a+b+cin against a reference model, with fixed latency on every operation.
